// File: rtl/fp_accum_pkg.sv
// Shared constants, state encoding and sign-extension helper for the FP32 burst accumulator.
package fp_accum_pkg;

    localparam int FX_W        = 21;
    localparam int FRAC_W      = 19;
    localparam int EXP_BIAS    = 127;
    localparam int EXP_ZERO_TH = 96;
    localparam int EXP_OVF_TH  = 128;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Signed value of {sign, int, frac}; callers truncate to their accumulator width.
    function automatic logic signed [63:0] fx_sext(input logic sign,
                                                   input logic int_bit,
                                                   input logic [FRAC_W-1:0] frac);
        logic signed [63:0] mag;
        mag = '0;
        mag[FX_W-2:0] = {int_bit, frac};
        return sign ? -mag : mag;
    endfunction

endpackage

// File: rtl/fp_to_fixed.sv
// Combinational FP32 -> unsigned 1.19 magnitude converter (truncating), sign passed through.
module fp_to_fixed
    import fp_accum_pkg::*;
(
    input  logic [31:0]       fp,
    output logic              sign,
    output logic              int_bit,
    output logic [FRAC_W-1:0] frac
);

    logic [7:0]  expo;
    logic [23:0] mant;
    logic [5:0]  sh;
    logic [19:0] shifted;
    logic        tiny;

    assign expo    = fp[30:23];
    assign mant    = {1'b1, fp[22:0]};
    // 1.0 (exp 127) lands at bit 19, so the right shift is (bias + 4) - exp.
    assign sh      = 6'(EXP_BIAS + 4 - int'(expo));
    assign shifted = 20'(mant >> sh);
    assign tiny    = expo < 8'(EXP_ZERO_TH);

    assign sign             = fp[31];
    assign {int_bit, frac}  = tiny ? '0 : shifted;

endmodule

// File: rtl/fp_accum_seq.sv
// Burst sequencer: converts FP32 samples to 1.19 fixed point and accumulates them.
// Optional clamp and sticky overflow flag enabled by FP_RANGE_CHECK_EN.
module fp_accum_seq
    import fp_accum_pkg::*;
#(
    parameter  int CNT_W = 10,
    localparam int ACC_W = FX_W + CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [CNT_W-1:0]        len_i,
    input  logic                    in_valid_i,
    input  logic [31:0]             in_data_i,
    output logic                    in_ready_o,
    output logic                    busy_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic signed [ACC_W-1:0] acc_o,
    output logic                    ovf_o
);

    state_t                   state;
    logic [CNT_W-1:0]         remaining;
    logic                     accept;
    logic                     c_sign;
    logic                     c_int;
    logic [FRAC_W-1:0]        c_frac;
    logic [FRAC_W:0]          c_mag;

    logic                     vld_p1;
    logic                     sign_p1;
    logic [FRAC_W:0]          mag_p1;
    logic                     vld_p2;
    logic signed [ACC_W-1:0]  val_p2;
    logic signed [ACC_W-1:0]  acc_q;

    assign accept = in_valid_i && in_ready_o;

    fp_to_fixed u_conv (
        .fp      (in_data_i),
        .sign    (c_sign),
        .int_bit (c_int),
        .frac    (c_frac)
    );

`ifdef FP_RANGE_CHECK_EN
    logic c_big;
    logic ovf_q;

    function automatic logic [FRAC_W:0] sat_mag(input logic big, input logic [FRAC_W:0] mag);
        return big ? '1 : mag;
    endfunction

    assign c_big = in_data_i[30:23] >= 8'(EXP_OVF_TH);
    assign c_mag = sat_mag(c_big, {c_int, c_frac});
    assign ovf_o = ovf_q;
`else
    assign c_mag = {c_int, c_frac};
    assign ovf_o = 1'b0;
`endif

    // Stage 1: converted fields captured on accept; stage 2: signed, extended value.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_p1 <= c_sign;
            mag_p1  <= c_mag;
        end
        val_p2 <= ACC_W'(fx_sext(sign_p1, mag_p1[FRAC_W], mag_p1[FRAC_W-1:0]));
    end

    // Control, valid pipeline and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            remaining   <= '0;
            in_ready_o  <= 1'b0;
            out_valid_o <= 1'b0;
            acc_q       <= '0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
`ifdef FP_RANGE_CHECK_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            vld_p1 <= accept;
            vld_p2 <= vld_p1;
            if (vld_p2) begin
                acc_q <= acc_q + val_p2;
            end
`ifdef FP_RANGE_CHECK_EN
            if (accept && c_big) begin
                ovf_q <= 1'b1;
            end
`endif
            case (state)
                IDLE: begin
                    if (start_i) begin
                        acc_q <= '0;
`ifdef FP_RANGE_CHECK_EN
                        ovf_q <= 1'b0;
`endif
                        if (len_i == '0) begin
                            state       <= DONE;
                            out_valid_o <= 1'b1;
                        end else begin
                            state      <= RUN;
                            remaining  <= len_i;
                            in_ready_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            state      <= DRAIN;
                            in_ready_o <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (!vld_p1 && !vld_p2) begin
                        state       <= DONE;
                        out_valid_o <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state       <= IDLE;
                        out_valid_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o = (state != IDLE);
    assign acc_o  = acc_q;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Randomized self-checking bench for fp_accum_seq against a real-arithmetic reference model.
module tb_fp_accum_seq;

    localparam int CNT_W = 10;
    localparam int ACC_W = 21 + CNT_W;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start_i = 1'b0;
    logic [CNT_W-1:0]        len_i = '0;
    logic                    in_valid_i = 1'b0;
    logic [31:0]             in_data_i = '0;
    logic                    in_ready_o;
    logic                    busy_o;
    logic                    out_valid_o;
    logic                    out_ready_i = 1'b0;
    logic signed [ACC_W-1:0] acc_o;
    logic                    ovf_o;

    fp_accum_seq #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .len_i       (len_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .busy_o      (busy_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .acc_o       (acc_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] samp [0:1023];
    int          gap  [0:1023];

    logic signed [ACC_W-1:0] obs_acc;
    int                      obs_lat;
    bit                      obs_stable;
    logic                    obs_rdy_after;

    // Value of an FP32 sample in units of 2^-19, truncated toward zero.
    function automatic longint model_fx(input logic [31:0] f);
        int     e;
        real    v;
        longint mag;
        e = int'(f[30:23]);
        if (e < 96) return 0;
`ifdef FP_RANGE_CHECK_EN
        if (e >= 128) return f[31] ? -longint'(20'hFFFFF) : longint'(20'hFFFFF);
`endif
        v = 1.0 + real'(f[22:0]) / 8388608.0;
        for (int i = e; i < 127; i++) v = v / 2.0;
        mag = longint'($floor(v * 524288.0));
        return f[31] ? -mag : mag;
    endfunction

    function automatic logic signed [ACC_W-1:0] model_sum(input int len);
        longint s;
        s = 0;
        for (int i = 0; i < len; i++) s += model_fx(samp[i]);
        return ACC_W'(s);
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        e = 8'($urandom_range(90, 127));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic run_burst(input int len, input int hold, input bit poke_start);
        int bound;
        @(negedge clk);
        start_i = 1'b1;
        len_i   = CNT_W'(len);
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < len; i++) begin
            repeat (gap[i]) @(negedge clk);
            in_valid_i = 1'b1;
            in_data_i  = samp[i];
            bound = 0;
            while (!in_ready_o && bound < 100) begin
                @(negedge clk);
                bound++;
            end
            if (poke_start && i == 1) begin
                start_i = 1'b1;
                len_i   = CNT_W'(1);
            end
            @(negedge clk);
            start_i    = 1'b0;
            in_valid_i = 1'b0;
        end
        obs_rdy_after = in_ready_o;
        obs_lat = 0;
        while (!out_valid_o && obs_lat < 50) begin
            @(negedge clk);
            obs_lat++;
        end
        obs_acc    = acc_o;
        obs_stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (acc_o !== obs_acc || out_valid_o !== 1'b1) obs_stable = 1'b0;
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready_o, busy_o, out_valid_o, ovf_o} !== 4'b0000 || acc_o !== '0) begin
            errors++;
            $display("FAIL reset: rdy=%b busy=%b ov=%b ovf=%b acc=%0h, expected all 0",
                     in_ready_o, busy_o, out_valid_o, ovf_o, acc_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        samp[0] = 32'h3F80_0000; samp[1] = 32'h3F00_0000; samp[2] = 32'hBE80_0000;
        for (int i = 0; i < 3; i++) gap[i] = 0;
        run_burst(3, 0, 1'b0);
        checks++;
        if (obs_acc !== ACC_W'(32'h000A_0000)) begin
            errors++;
            $display("FAIL basic_acc: got %0h expected a0000", obs_acc);
        end
        checks++;
        if (obs_lat !== 3) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 3", obs_lat);
        end
        checks++;
        if (obs_rdy_after !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_drop: got %b expected 0", obs_rdy_after);
        end
        checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: busy=%b ov=%b expected 0 0", busy_o, out_valid_o);
        end
    endtask

    task automatic test_gaps();
        samp[0] = 32'h3F80_0000; samp[1] = 32'h3F00_0000; samp[2] = 32'hBE80_0000;
        gap[0] = 0; gap[1] = 2; gap[2] = 5;
        run_burst(3, 10, 1'b0);
        checks++;
        if (obs_acc !== model_sum(3)) begin
            errors++;
            $display("FAIL gaps_acc: got %0h expected %0h", obs_acc, model_sum(3));
        end
        checks++;
        if (obs_stable !== 1'b1) begin
            errors++;
            $display("FAIL gaps_hold: result not held while out_ready low (got %b expected 1)", obs_stable);
        end
        checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL gaps_idle: busy=%b ov=%b expected 0 0", busy_o, out_valid_o);
        end
    endtask

    task automatic test_len0_and_ignore();
        @(negedge clk);
        start_i = 1'b1;
        len_i   = '0;
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b1 || acc_o !== '0 || in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL len0: ov=%b acc=%0h rdy=%b expected 1 0 0", out_valid_o, acc_o, in_ready_o);
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            samp[i] = rand_fp();
            gap[i]  = 0;
        end
        run_burst(4, 0, 1'b1);
        checks++;
        if (obs_acc !== model_sum(4) || obs_lat !== 3) begin
            errors++;
            $display("FAIL start_ignored: acc=%0h lat=%0d expected %0h lat 3", obs_acc, obs_lat, model_sum(4));
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_idle: busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_long();
        for (int i = 0; i < 1023; i++) begin
            samp[i] = 32'h3F80_0000;
            gap[i]  = 0;
        end
        run_burst(1023, 0, 1'b0);
        checks++;
        if (obs_acc !== ACC_W'(longint'(1023) << 19)) begin
            errors++;
            $display("FAIL long_acc: got %0h expected %0h", obs_acc, ACC_W'(longint'(1023) << 19));
        end
    endtask

    task automatic test_small_exp();
        samp[0] = 32'h2F80_0000; samp[1] = 32'h3F80_0000; samp[2] = 32'h8000_0000;
        for (int i = 0; i < 3; i++) gap[i] = 1;
        run_burst(3, 0, 1'b0);
        checks++;
        if (obs_acc !== ACC_W'(32'h0008_0000)) begin
            errors++;
            $display("FAIL small_exp: got %0h expected 80000", obs_acc);
        end
    endtask

    task automatic test_random();
        int len;
        for (int b = 0; b < 6; b++) begin
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                samp[i] = rand_fp();
                gap[i]  = $urandom_range(0, 2);
            end
            run_burst(len, $urandom_range(0, 3), 1'b0);
            checks++;
            if (obs_acc !== model_sum(len) || obs_lat !== 3) begin
                errors++;
                $display("FAIL random_%0d: acc=%0h lat=%0d expected %0h lat 3",
                         b, obs_acc, obs_lat, model_sum(len));
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start_i = 1'b1;
        len_i   = CNT_W'(5);
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 32'h3F80_0000;
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready_o, busy_o, out_valid_o, ovf_o} !== 4'b0000 || acc_o !== '0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b busy=%b ov=%b ovf=%b acc=%0h, expected all 0",
                     in_ready_o, busy_o, out_valid_o, ovf_o, acc_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        samp[0] = 32'hBF00_0000;
        gap[0]  = 0;
        run_burst(1, 0, 1'b0);
        checks++;
        if (obs_acc !== -ACC_W'(32'h0004_0000)) begin
            errors++;
            $display("FAIL after_reset: got %0h expected -40000", obs_acc);
        end
    endtask

`ifdef FP_RANGE_CHECK_EN
    task automatic test_range();
        samp[0] = 32'h4000_0000; samp[1] = 32'hFF80_0000;
        gap[0] = 0; gap[1] = 0;
        run_burst(2, 0, 1'b0);
        checks++;
        if (obs_acc !== model_sum(2) || ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL range: acc=%0h ovf=%b expected %0h ovf 1", obs_acc, ovf_o, model_sum(2));
        end
        @(negedge clk);
        start_i = 1'b1;
        len_i   = '0;
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL range_clear: ovf=%b expected 0", ovf_o);
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_len0_and_ignore();
        test_long();
        test_small_exp();
        test_random();
        test_reset_mid();
`ifdef FP_RANGE_CHECK_EN
        test_range();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
